// File: rtl/mem_pkg.sv
// Shared packet-memory definitions: slot geometry, reader FSM states and
// the BRAM address composer used by both the write and read sides.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif

package mem_pkg;

  localparam int SLOT_ID_W  = 4;
  localparam int SLOT_OFF_W = 6;
  localparam int ADDR_MAX_W = 64;

  typedef logic [1:0] rd_state_t;

  localparam rd_state_t IDLE  = 2'd0;
  localparam rd_state_t READ  = 2'd1;
  localparam rd_state_t DRAIN = 2'd2;

  // Word address of (slot, offset): {pad, id, offset}
  function automatic logic [ADDR_MAX_W-1:0] slot_addr(
    input logic [ADDR_MAX_W-1:0] id,
    input logic [ADDR_MAX_W-1:0] off,
    input int                    off_w
  );
    return (id << off_w) | off;
  endfunction

endpackage

// File: rtl/pkt_rd_fifo.sv
// Small synchronous FIFO holding read words (data, keep, last) between the
// BRAM return path and the streaming output.
module pkt_rd_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 3,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_pop, full;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign do_pop = pop && !empty;
  assign dout   = mem[rd_ptr];

  // Depth need not be a power of two, so pointers wrap explicitly
  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= nxt(wr_ptr);
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge CLK) disable iff (reset)
    !(push && full && !do_pop));

endmodule

// File: rtl/mem_pkt_reader.sv
// Read-side engine for the packet BRAM: fetches a slot's words over port B
// and streams them out with keep/last, then reports the slot as done.
module mem_pkt_reader
  import mem_pkg::*;
#(
  parameter int DATA_W     = `BUS_WIDTH,
  parameter int KEEP_W     = DATA_W / 8,
  parameter int ID_W       = SLOT_ID_W,
  parameter int OFF_W      = SLOT_OFF_W,
  parameter int ADDR_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ID_W-1:0]   req_id,
  input  logic [OFF_W:0]    req_len,
  input  logic [KEEP_W-1:0] req_last_keep,
  output logic              mem_enb,
  output logic [ADDR_W-1:0] mem_r_addr,
  input  logic [DATA_W-1:0] mem_data_o,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic              out_last,
  output logic              done,
  output logic [ID_W-1:0]   done_id
);

  localparam int DEPTH  = RD_LATENCY + 2;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int FIFO_W = DATA_W + KEEP_W + 1;
  localparam logic [OFF_W:0] MAX_LEN = {1'b1, {OFF_W{1'b0}}};
  localparam logic [OFF_W:0] ONE     = {{OFF_W{1'b0}}, 1'b1};

  rd_state_t             state;
  logic [ID_W-1:0]       id_q;
  logic [OFF_W:0]        len_q, issued, beat;
  logic [KEEP_W-1:0]     keep_q;
  logic [RD_LATENCY-1:0] vld_pipe;
  logic [CNT_W-1:0]      fifo_cnt, inflight;
  logic                  fifo_empty, push, pop, push_last, drain_ok;
  logic [FIFO_W-1:0]     fifo_din, fifo_dout;

  assign req_ready = (state == IDLE) && !reset;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CNT_W'(vld_pipe[i]);
  end

  // Credit check: words in the FIFO plus words in flight never exceed DEPTH
  assign mem_enb = (state == READ) && (issued < len_q) &&
                   ((CNT_W+1)'(fifo_cnt) + (CNT_W+1)'(inflight) < (CNT_W+1)'(DEPTH));
  assign mem_r_addr = ADDR_W'(slot_addr(ADDR_MAX_W'(id_q), ADDR_MAX_W'(issued[OFF_W-1:0]), OFF_W));

  // Keep/last are decided as words enter the FIFO, so the head is self-contained
  assign push      = vld_pipe[RD_LATENCY-1];
  assign push_last = (beat == len_q - ONE);
  assign fifo_din  = {mem_data_o, push_last ? keep_q : {KEEP_W{1'b1}}, push_last};

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign {out_data, out_keep, out_last} = out_valid ? fifo_dout : '0;

  assign drain_ok = (len_q == '0) ? (fifo_empty && (vld_pipe == '0)) : (pop && out_last);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      id_q     <= '0;
      len_q    <= '0;
      keep_q   <= '0;
      issued   <= '0;
      beat     <= '0;
      vld_pipe <= '0;
      done     <= 1'b0;
      done_id  <= '0;
    end else begin
      done        <= 1'b0;
      vld_pipe[0] <= mem_enb;
      for (int i = 1; i < RD_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
      if (push) beat <= beat + ONE;
      case (state)
        IDLE: if (req_valid) begin
          id_q   <= req_id;
          len_q  <= (req_len > MAX_LEN) ? MAX_LEN : req_len;
          keep_q <= req_last_keep;
          issued <= '0;
          beat   <= '0;
          state  <= (req_len == '0) ? DRAIN : READ;
        end
        READ: if (mem_enb) begin
          issued <= issued + ONE;
          if (issued + ONE == len_q) state <= DRAIN;
        end
        DRAIN: if (drain_ok) begin
          state   <= IDLE;
          done    <= 1'b1;
          done_id <= id_q;
        end
        default: state <= IDLE;
      endcase
    end
  end

  pkt_rd_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .reset (reset),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

endmodule
